// File: rtl/rab_pkg.sv
// Shared types for the RAB slave-side address requesters: requester FSM
// states and the buffered AXI address beat.
package rab_pkg;

  // Beat field widths. The requester ports are sized from the same values,
  // so a requester instantiated with other ID/USER widths must be paired
  // with a matching edit here.
  localparam int unsigned RAB_ADDR_W = 32;
  localparam int unsigned RAB_ID_W   = 8;
  localparam int unsigned RAB_LEN_W  = 8;
  localparam int unsigned RAB_SIZE_W = 3;
  localparam int unsigned RAB_USER_W = 6;

  // Requester life cycle of the beat at the FIFO head.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,  // nothing buffered
    LOOKUP = 3'd1,  // head presented to the core, waiting for a verdict
    ISSUE  = 3'd2,  // translated head offered to the master side
    SENT   = 3'd3,  // completion pulse back to the core
    DROP   = 3'd4   // head offered to the error-response generator
  } req_state_e;

  // One AXI address beat as buffered by the requester.
  typedef struct packed {
    logic [RAB_ADDR_W-1:0] addr;
    logic [RAB_ID_W-1:0]   id;
    logic [RAB_LEN_W-1:0]  len;
    logic [RAB_SIZE_W-1:0] size;
    logic [RAB_USER_W-1:0] user;
  } ax_beat_t;

endpackage : rab_pkg

// File: rtl/rab_ax_fifo.sv
// Synchronous FIFO of AXI address beats with a synchronous active-high
// reset. DEPTH must be a power of two so the pointers wrap naturally; the
// count carries one extra bit so that full and empty are distinct.
module rab_ax_fifo
  import rab_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  ax_beat_t                 i_data,
  input  logic                     i_pop,
  output ax_beat_t                 o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  ax_beat_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  // Overflow and underflow requests are ignored rather than corrupting state.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Beat storage: written on push only.
  // NOTE: the storage array has no reset; validity is tracked by the count,
  // and leaving it unreset lets it map onto plain RAM/register cells.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : rab_ax_fifo

// File: rtl/rab_ax_requester.sv
// Slave-side AR/AW requester of the RAB core. Buffers incoming address
// beats, presents the oldest one to the core for translation, then either
// forwards the translated beat to the master side (accept) or hands its
// ID/LEN to the error-response generator (drop). One lookup at a time,
// strictly in order.
module rab_ax_requester
  import rab_pkg::*;
#(
  parameter int unsigned C_AXI_ID_WIDTH   = RAB_ID_W,
  parameter int unsigned C_AXI_USER_WIDTH = RAB_USER_W,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter bit          IS_WRITE         = 1'b0
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  // incoming beat
  input  logic [31:0]                 s_ax_addr,
  input  logic [C_AXI_ID_WIDTH-1:0]   s_ax_id,
  input  logic [7:0]                  s_ax_len,
  input  logic [2:0]                  s_ax_size,
  input  logic [C_AXI_USER_WIDTH-1:0] s_ax_user,
  input  logic                        s_ax_valid,
  output logic                        s_ax_ready,
  // translation request to the core
  output logic [31:0]                 rab_addr,
  output logic [C_AXI_ID_WIDTH-1:0]   rab_id,
  output logic [7:0]                  rab_len,
  output logic [2:0]                  rab_size,
  output logic [C_AXI_USER_WIDTH-1:0] rab_ctrl,
  output logic                        rab_type,
  output logic                        rab_addr_valid,
  input  logic                        rab_accept,
  input  logic                        rab_drop,
  input  logic [31:0]                 rab_out_addr,
  input  logic                        rab_master_select,
  output logic                        rab_sent,
  // translated outgoing beat
  output logic [31:0]                 m_ax_addr,
  output logic [C_AXI_ID_WIDTH-1:0]   m_ax_id,
  output logic [7:0]                  m_ax_len,
  output logic [2:0]                  m_ax_size,
  output logic [C_AXI_USER_WIDTH-1:0] m_ax_user,
  output logic                        m_ax_master_select,
  output logic                        m_ax_valid,
  input  logic                        m_ax_ready,
  // dropped beat to the response generator
  output logic [C_AXI_ID_WIDTH-1:0]   drop_id,
  output logic [7:0]                  drop_len,
  output logic                        drop_valid,
  input  logic                        drop_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] ONE_LEFT = CNT_W'(1);

  req_state_e r_state;
  logic       r_addr_valid;
  logic       r_m_valid;
  logic       r_drop_valid;
  logic       r_sent;
  logic [31:0] r_out_addr;
  logic        r_master_sel;

  ax_beat_t         w_in_beat;
  ax_beat_t         w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_push;
  logic             w_pop;
  logic             w_m_hs;
  logic             w_drop_hs;

  assign w_in_beat = '{addr: s_ax_addr, id: s_ax_id, len: s_ax_len,
                       size: s_ax_size, user: s_ax_user};

  assign s_ax_ready = ~w_full;
  assign w_push     = s_ax_valid & ~w_full;
  assign w_m_hs     = r_m_valid & m_ax_ready;
  assign w_drop_hs  = r_drop_valid & drop_ready;
  // The head leaves the buffer once the master side or the response
  // generator has taken it.
  assign w_pop      = w_m_hs | w_drop_hs;

  rab_ax_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (s_axi_aclk),
    .rst     (s_axi_areset),
    .i_push  (w_push),
    .i_data  (w_in_beat),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Requester FSM with registered handshake flags; each flag is set on the
  // transition into the state that owns it, so outputs follow the state.
  // NOTE: sequential state uses <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state      <= IDLE;
      r_addr_valid <= 1'b0;
      r_m_valid    <= 1'b0;
      r_drop_valid <= 1'b0;
      r_sent       <= 1'b0;
      r_out_addr   <= '0;
      r_master_sel <= 1'b0;
    end else begin
      r_sent <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state      <= LOOKUP;
            r_addr_valid <= 1'b1;
          end
        end
        LOOKUP: begin
          // Accept takes precedence when the core raises both verdicts.
          if (rab_accept) begin
            r_state      <= ISSUE;
            r_addr_valid <= 1'b0;
            r_m_valid    <= 1'b1;
            r_out_addr   <= rab_out_addr;
            r_master_sel <= rab_master_select;
          end else if (rab_drop) begin
            r_state      <= DROP;
            r_addr_valid <= 1'b0;
            r_drop_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (m_ax_ready) begin
            r_state   <= SENT;
            r_m_valid <= 1'b0;
            r_sent    <= 1'b1;
          end
        end
        SENT: begin
          // The pop happened on entry, so the count is already current.
          if (!w_empty) begin
            r_state      <= LOOKUP;
            r_addr_valid <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        DROP: begin
          if (drop_ready) begin
            r_drop_valid <= 1'b0;
            // The head pops on this edge; anything beyond it keeps the
            // pipeline busy, a beat pushed this cycle is picked up via IDLE.
            if (w_count > ONE_LEFT) begin
              r_state      <= LOOKUP;
              r_addr_valid <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_addr_valid <= 1'b0;
          r_m_valid    <= 1'b0;
          r_drop_valid <= 1'b0;
        end
      endcase
    end
  end

  // Conflicting verdicts are tolerated (accept wins) but reported.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_areset && r_state == LOOKUP) begin
      assert (!(rab_accept && rab_drop))
        else $warning("rab_ax_requester: rab_accept and rab_drop both high, accept takes precedence");
    end
  end

  // Output fields come from the FIFO head and are held at zero whenever
  // their handshake is idle, so nothing stale leaks out after reset.
  // NOTE: every output gets a default before the conditional updates, which
  // keeps this block purely combinational (no latches).
  always_comb begin
    rab_addr           = '0;
    rab_id             = '0;
    rab_len            = '0;
    rab_size           = '0;
    rab_ctrl           = '0;
    m_ax_addr          = '0;
    m_ax_id            = '0;
    m_ax_len           = '0;
    m_ax_size          = '0;
    m_ax_user          = '0;
    m_ax_master_select = 1'b0;
    drop_id            = '0;
    drop_len           = '0;
    if (r_addr_valid) begin
      rab_addr = w_head.addr;
      rab_id   = w_head.id;
      rab_len  = w_head.len;
      rab_size = w_head.size;
      rab_ctrl = w_head.user;
    end
    if (r_m_valid) begin
      m_ax_addr          = r_out_addr;
      m_ax_id            = w_head.id;
      m_ax_len           = w_head.len;
      m_ax_size          = w_head.size;
      m_ax_user          = w_head.user;
      m_ax_master_select = r_master_sel;
    end
    if (r_drop_valid) begin
      drop_id  = w_head.id;
      drop_len = w_head.len;
    end
  end

  assign rab_type       = IS_WRITE;
  assign rab_addr_valid = r_addr_valid;
  assign rab_sent       = r_sent;
  assign m_ax_valid     = r_m_valid;
  assign drop_valid     = r_drop_valid;

endmodule : rab_ax_requester
